axil_req_arbiter: RTL and testbench
===================================

AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning byte-address width of requests and the AXI-Lite master port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; wstrb width is DATA_WIDTH/8.
REQ-003 SHALL have clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have rst_i  input  1  reset; asynchronous assertion, active-high.
REQ-005 SHALL have req_valid  input  2  per-requester transaction request, bit n = requester n.
REQ-006 SHALL have req_write  input  2  per-requester direction: 1 = write, 0 = read.
REQ-007 SHALL have req_addr  input  2*ADDR_WIDTH  per-requester address; requester n uses slice n.
REQ-008 SHALL have req_wdata  input  2*DATA_WIDTH  per-requester write data; requester n uses slice n.
REQ-009 SHALL have req_ready  output  2  one-cycle pulse when the request is accepted and captured.
REQ-010 SHALL have rsp_valid  output  2  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have rsp_rdata  output  DATA_WIDTH  read data, shared, valid with rsp_valid.
REQ-012 SHALL have rsp_err  output  1  1 when the completed transaction's bresp or rresp is not 2'b00.
REQ-013 SHALL have m_axil_awaddr  output  ADDR_WIDTH, m_axil_awprot  output  3 (constant 3'b000), m_axil_awvalid  output  1, m_axil_awready  input  1.
REQ-014 SHALL have m_axil_wdata  output  DATA_WIDTH, m_axil_wstrb  output  DATA_WIDTH/8 (constant all ones), m_axil_wvalid  output  1, m_axil_wready  input  1.
REQ-015 SHALL have m_axil_bresp  input  2, m_axil_bvalid  input  1, m_axil_bready  output  1.
REQ-016 SHALL have m_axil_araddr  output  ADDR_WIDTH, m_axil_arprot  output  3 (constant 3'b000), m_axil_arvalid  output  1, m_axil_arready  input  1.
REQ-017 SHALL have m_axil_rdata  input  DATA_WIDTH, m_axil_rresp  input  2, m_axil_rvalid  input  1, m_axil_rready  output  1.

Function
REQ-018 SHALL implement FSM states IDLE, WADDR, WRESP, RADDR, RRESP, DONE; exactly one transaction outstanding at a time.
REQ-019 SHALL, in IDLE with any req_valid bit set, grant one requester, pulse its req_ready for that cycle only, capture its write/addr/wdata, and move to WADDR (write) or RADDR (read) next cycle.
REQ-020 SHALL arbitrate round-robin: with both bits set, grant the requester not granted last; with one bit set, grant it regardless of history; record the grant in last_grant.
REQ-021 SHALL, in WADDR, assert awvalid and wvalid together from the first cycle; deassert each only after its own valid&ready handshake; hold address/data stable while valid; move to WRESP once both handshakes have completed, whether on the same or different cycles.
REQ-022 SHALL, in WRESP, assert bready; on bvalid capture bresp, set captured rdata to 0, and move to DONE.
REQ-023 SHALL, in RADDR, assert arvalid until arready, then move to RRESP; in RRESP assert rready; on rvalid capture rdata and rresp and move to DONE.
REQ-024 SHALL, in DONE, pulse rsp_valid for the granted requester for exactly one cycle with rsp_rdata/rsp_err, then return to IDLE; rsp_rdata/rsp_err hold their values until the next DONE.
REQ-025 SHALL never drive a valid while in IDLE or DONE; no new request is accepted from req_ready until the cycle after DONE, so back-to-back grants are at least one IDLE cycle apart.
REQ-026 SHALL ignore req_valid changes after acceptance; a requester that drops req_valid before its grant is not served.
REQ-027 SHALL take no timeout action: a slave that never responds stalls the FSM until reset.

Reset
REQ-028 SHALL, while rst_i is high, immediately force IDLE, clear all valids, req_ready, rsp_valid, bready, rready, rsp_rdata and rsp_err to 0, set last_grant = 1 so requester 0 wins the first tie, and abandon any in-flight transaction without a rsp_valid.

Verification
REQ-029 SHALL verify single write: req0 write addr 0x4 data 0xDEADBEEF -> req_ready[0] pulse; aw/w handshake; rsp_valid[0] one cycle; rsp_err=0; a read of 0x4 returns 0xDEADBEEF.
REQ-030 SHALL verify tie arbitration: both requesters valid every cycle after reset -> grants in order 0,1,0,1 and each rsp_valid goes only to its owner.
REQ-031 SHALL verify split write handshake: slave delays wready 3 cycles after awready -> awvalid drops after its handshake, wvalid stays high, then one bresp, then rsp_valid.
REQ-032 SHALL verify error path: slave returns rresp=2'b10 with rdata 0x12345678 -> rsp_err=1 and rsp_rdata=0x12345678.
REQ-033 SHALL verify reset mid-transaction: rst_i asserted while in WRESP -> all outputs 0 in that same cycle, no rsp_valid, and requester 0 wins the first tie after release.
REQ-034 SHALL verify a single requester repeating 3 reads: each is accepted with no starvation by history, and rsp_valid fires once per read.

Source files
------------

// File: rtl/axil_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axil_req_arbiter
//  Purpose  : Two-requester round-robin arbiter in front of a single AXI-Lite
//             master port. One transaction is in flight at a time. A granted
//             request is captured, driven onto the AXI-Lite channels, and its
//             completion (read data and error flag) is returned to the owner.
//  Ports    : clk_i, rst_i          - clock, async active-high reset
//             req_valid/req_write   - per-requester request and direction
//             req_addr/req_wdata    - per-requester address and write data
//             req_ready             - one-cycle accept pulse per requester
//             rsp_valid             - one-cycle completion pulse per requester
//             rsp_rdata/rsp_err     - shared completion data and error flag
//             m_axil_*              - AXI-Lite master (AW, W, B, AR, R)
//  Revision : 1.0  initial release
// ============================================================================
module axil_req_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,

  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,

  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,

  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,

  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,

  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,

  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  localparam int C_STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RRESP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q,      owner_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic                  aw_done_q,    aw_done_d;
  logic                  w_done_q,     w_done_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,  rsp_rdata_d;
  logic                  rsp_err_q,    rsp_err_d;

  logic                  w_any_req;
  logic                  w_grant_idx;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_aw_hs;
  logic                  w_w_hs;

  // --------------------------------------------------------------------------
  // Round-robin pick: on a tie the requester that did not win last time gets
  // the grant; a lone requester always wins regardless of history.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any_req = |req_valid;
    if (req_valid == 2'b11) begin
      w_grant_idx = ~last_grant_q;
    end else begin
      w_grant_idx = req_valid[1];
    end
    w_sel_write = w_grant_idx ? req_write[1] : req_write[0];
    w_sel_addr  = w_grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : req_addr[ADDR_WIDTH-1:0];
    w_sel_wdata = w_grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_wdata[DATA_WIDTH-1:0];
  end

  // AW and W complete independently; each valid drops after its own handshake.
  assign m_axil_awvalid = (state_q == S_WADDR) && !aw_done_q;
  assign m_axil_wvalid  = (state_q == S_WADDR) && !w_done_q;
  assign m_axil_bready  = (state_q == S_WRESP);
  assign m_axil_arvalid = (state_q == S_RADDR);
  assign m_axil_rready  = (state_q == S_RRESP);

  assign w_aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_w_hs  = m_axil_wvalid  && m_axil_wready;

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = {C_STRB_WIDTH{1'b1}};

  // The accept pulse is combinational from IDLE; it is masked by rst_i so it
  // is already low in the cycle reset arrives, not only after the flops clear.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == S_IDLE) && w_any_req && !rst_i) begin
      req_ready = w_grant_idx ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == S_DONE) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
    end
  end

  // Completion data is registered so it stays put between completions.
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // --------------------------------------------------------------------------
  // Next-state and capture logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          owner_d      = w_grant_idx;
          last_grant_d = w_grant_idx;
          addr_d       = w_sel_addr;
          wdata_d      = w_sel_wdata;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          state_d      = w_sel_write ? S_WADDR : S_RADDR;
        end
      end

      S_WADDR: begin
        aw_done_d = aw_done_q || w_aw_hs;
        w_done_d  = w_done_q  || w_w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = S_WRESP;
        end
      end

      S_WRESP: begin
        if (m_axil_bvalid) begin
          rsp_err_d   = (m_axil_bresp != 2'b00);
          rsp_rdata_d = '0;
          state_d     = S_DONE;
        end
      end

      S_RADDR: begin
        if (m_axil_arready) begin
          state_d = S_RRESP;
        end
      end

      S_RRESP: begin
        if (m_axil_rvalid) begin
          rsp_err_d   = (m_axil_rresp != 2'b00);
          rsp_rdata_d = m_axil_rdata;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_req_arbiter
//  Purpose  : Self-checking bench for axil_req_arbiter with a behavioural
//             AXI-Lite slave and a grant/response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axil_req_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr  = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   m_axil_awaddr;
  logic [2:0]      m_axil_awprot;
  logic            m_axil_awvalid;
  logic            m_axil_awready = 1'b0;
  logic [DW-1:0]   m_axil_wdata;
  logic [DW/8-1:0] m_axil_wstrb;
  logic            m_axil_wvalid;
  logic            m_axil_wready = 1'b0;
  logic [1:0]      m_axil_bresp = '0;
  logic            m_axil_bvalid = 1'b0;
  logic            m_axil_bready;
  logic [AW-1:0]   m_axil_araddr;
  logic [2:0]      m_axil_arprot;
  logic            m_axil_arvalid;
  logic            m_axil_arready = 1'b0;
  logic [DW-1:0]   m_axil_rdata = '0;
  logic [1:0]      m_axil_rresp = '0;
  logic            m_axil_rvalid = 1'b0;
  logic            m_axil_rready;

  axil_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int   exp_gnt[$];
  rsp_t exp_rsp[$];

  initial begin
    forever begin
      @(negedge clk_i);
      if (req_ready != 2'b00) begin
        if (exp_gnt.size() == 0) chk("gnt_extra", req_ready, 0);
        else begin
          int g;
          g = exp_gnt.pop_front();
          chk("gnt_owner", req_ready, (g == 0) ? 2'b01 : 2'b10);
        end
      end
      if (rsp_valid != 2'b00) begin
        if (exp_rsp.size() == 0) chk("rsp_extra", rsp_valid, 0);
        else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_owner", rsp_valid, (e.owner == 0) ? 2'b01 : 2'b10);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err",   rsp_err,   e.err);
        end
      end
    end
  end

  // ---------------- AXI-Lite slave model ----------------
  logic [31:0] mem [4];
  int          w_delay   = 0;
  bit          stall_b   = 0;
  logic [1:0]  resp_code = 2'b00;
  bit          rd_ovr_en = 0;
  logic [31:0] rd_ovr    = '0;
  int          aw_late_cnt = 0;
  int          skew_cnt    = 0;
  int          w_wait_cnt  = 0;
  int          b_hs_cnt    = 0;

  initial begin
    bit         aw_got, w_got, b_pend, r_pend;
    bit         hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [3:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    int         wcnt;
    bit         w_ok;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; wcnt = 0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; wcnt = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
        m_axil_arready = 0; m_axil_rvalid = 0;
      end else begin
        if (hs_aw) aw_got = 1;
        if (hs_w)  w_got  = 1;
        if (hs_b) begin b_pend = 0; b_hs_cnt++; end
        if (hs_ar) r_pend = 1;
        if (hs_r)  r_pend = 0;
        if (aw_got && w_got) begin
          mem[s_awaddr[3:2]] = s_wdata;
          b_pend = 1; aw_got = 0; w_got = 0; wcnt = 0;
        end
        if (aw_got && m_axil_awvalid) aw_late_cnt++;
        if (!aw_got && !w_got && (m_axil_awvalid != m_axil_wvalid)) skew_cnt++;
        m_axil_awready = m_axil_awvalid && !aw_got;
        w_ok = (w_delay == 0) || (aw_got && wcnt >= w_delay);
        m_axil_wready = m_axil_wvalid && !w_got && w_ok;
        if (aw_got && !w_got && m_axil_wvalid && !m_axil_wready) w_wait_cnt++;
        if (aw_got && !w_got) wcnt++;
        m_axil_bvalid  = b_pend && !stall_b;
        m_axil_bresp   = resp_code;
        m_axil_arready = m_axil_arvalid && !r_pend;
        m_axil_rvalid  = r_pend;
        m_axil_rdata   = rd_ovr_en ? rd_ovr : mem[s_araddr[3:2]];
        m_axil_rresp   = resp_code;
        hs_aw = m_axil_awvalid && m_axil_awready;
        hs_w  = m_axil_wvalid  && m_axil_wready;
        hs_b  = m_axil_bvalid  && m_axil_bready;
        hs_ar = m_axil_arvalid && m_axil_arready;
        hs_r  = m_axil_rvalid  && m_axil_rready;
        if (hs_aw) s_awaddr = m_axil_awaddr;
        if (hs_w)  s_wdata  = m_axil_wdata;
        if (hs_ar) s_araddr = m_axil_araddr;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] out_vec();
    return {req_ready, rsp_valid, rsp_rdata, rsp_err, m_axil_awvalid,
            m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready};
  endfunction

  task automatic set_req(input int n, input bit wr, input logic [3:0] a, input logic [31:0] d);
    req_write[n] = wr;
    req_addr[n*AW +: AW] = a;
    req_wdata[n*DW +: DW] = d;
  endtask

  task automatic issue(input int n, input bit wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] er, input bit ee, input bit push_rsp);
    bit got;
    rsp_t e;
    got = 0;
    exp_gnt.push_back(n);
    if (push_rsp) begin
      e.owner = n; e.rdata = er; e.err = ee;
      exp_rsp.push_back(e);
    end
    @(posedge clk_i); #1;
    set_req(n, wr, a, d);
    req_valid[n] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (req_ready[n]) begin got = 1; break; end
    end
    if (!got) chk("grant_timeout", 0, 1);
    @(posedge clk_i); #1;
    req_valid[n] = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk_i);
      if (req_ready != 2'b00) seen++;
    end
    if (seen < n) chk("grants_timeout", seen, n);
    @(posedge clk_i); #1;
    req_valid = 2'b00;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_gnt.size() == 0 && exp_rsp.size() == 0) break;
      @(negedge clk_i);
    end
    if (i == 200) chk("drain_timeout", exp_rsp.size(), 0);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=0x0 exp=0x1");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0, c1, c2, c3;
    rsp_t e;
    #2;
    chk("reset_outputs", out_vec(), 64'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_outputs", out_vec(), 64'h0);
    chk("const_prot_strb", {m_axil_awprot, m_axil_arprot, m_axil_wstrb}, {6'b0, 4'hF});

    // single write then read-back
    issue(0, 1, 4'h4, 32'hDEADBEEF, 32'h0, 0, 1);
    drain();
    issue(0, 0, 4'h4, 32'h0, 32'hDEADBEEF, 0, 1);
    drain();
    chk("aw_w_together", skew_cnt, 0);

    // tie arbitration from reset: 0,1,0,1
    do_reset();
    set_req(0, 1, 4'h8, 32'hA5A50000);
    set_req(1, 0, 4'h4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_gnt.push_back(k % 2);
      e.owner = k % 2;
      e.rdata = (k % 2 == 1) ? 32'hDEADBEEF : 32'h0;
      e.err   = 1'b0;
      exp_rsp.push_back(e);
    end
    req_valid = 2'b11;
    wait_grants(4);
    drain();

    // split write handshake: wready held off 3 cycles after AW
    c0 = aw_late_cnt; c1 = w_wait_cnt; c2 = b_hs_cnt; c3 = skew_cnt;
    w_delay = 3;
    issue(0, 1, 4'hC, 32'h0BADF00D, 32'h0, 0, 1);
    drain();
    w_delay = 0;
    chk("split_aw_dropped", aw_late_cnt - c0, 0);
    chk("split_w_waited",   w_wait_cnt - c1, 3);
    chk("split_one_b",      b_hs_cnt - c2, 1);
    chk("split_start_skew", skew_cnt - c3, 0);

    // error read response
    resp_code = 2'b10; rd_ovr_en = 1; rd_ovr = 32'h12345678;
    issue(1, 0, 4'h0, 32'h0, 32'h12345678, 1, 1);
    drain();
    resp_code = 2'b00; rd_ovr_en = 0;
    repeat (3) @(negedge clk_i);
    chk("hold_rdata", rsp_rdata, 32'h12345678);
    chk("hold_err",   rsp_err, 1);

    // reset while waiting for the write response
    stall_b = 1;
    issue(0, 1, 4'h0, 32'h11, 32'h0, 0, 0);
    c0 = 0;
    for (int i = 0; i < 20 && !m_axil_bready; i++) @(negedge clk_i);
    chk("in_wresp", m_axil_bready, 1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    set_req(0, 1, 4'h0, 32'h11);
    set_req(1, 0, 4'h8, 32'h0);
    req_valid = 2'b11;
    #1;
    chk("reset_mid_outputs", out_vec(), 64'h0);
    repeat (2) @(posedge clk_i);
    stall_b = 0;
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    e.owner = 0; e.rdata = 32'h0; e.err = 0;
    exp_rsp.push_back(e);
    e.owner = 1; e.rdata = 32'hA5A50000; e.err = 0;
    exp_rsp.push_back(e);
    #1 rst_i = 1'b0;
    wait_grants(2);
    drain();

    // single requester, three reads in a row
    issue(1, 0, 4'h4, 32'h0, 32'hDEADBEEF, 0, 1);
    issue(1, 0, 4'h8, 32'h0, 32'hA5A50000, 0, 1);
    issue(1, 0, 4'hC, 32'h0, 32'h0BADF00D, 0, 1);
    drain();
    chk("queues_empty", exp_gnt.size() + exp_rsp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
